// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encodings
// and the default operand width.
package div_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// subtract the divisor if it fits, and emit the quotient bit.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // A set top bit means the shifted value exceeds any WIDTH-bit divisor.
    assign w_shift = {rem_in[WIDTH-1:0], next_bit};
    assign w_ge    = rem_in[WIDTH] | (w_shift >= {1'b0, divisor});
    assign w_diff  = w_shift - {1'b0, divisor};
    assign rem_out = w_ge ? w_diff : w_shift;
    assign q_bit   = w_ge;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock,
// with valid/ready handshakes and divide-by-zero flagging.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic             r_dz;

    logic [WIDTH:0]   w_rem_step;
    logic             w_q_bit;
    logic             w_accept;
    logic             w_zero;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in   (r_rem),
        .next_bit (r_dvd[WIDTH-1]),
        .divisor  (r_dvs),
        .rem_out  (w_rem_step),
        .q_bit    (w_q_bit)
    );

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign quotient    = r_q;
    assign remainder   = r_rem[WIDTH-1:0];
    assign div_by_zero = r_dz;
    assign w_accept    = in_valid && in_ready;
    assign w_zero      = (divisor == '0);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_zero ? ST_DONE : ST_BUSY;
            ST_BUSY: if (r_cnt == LAST) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_dvd <= '0;
            r_dvs <= '0;
            r_rem <= '0;
            r_q   <= '0;
            r_dz  <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_accept) begin
                r_dvd <= dividend;
                r_dvs <= divisor;
                r_cnt <= '0;
                r_dz  <= w_zero;
                // Divide by zero skips iteration and reports q=all-ones, r=dividend.
                r_q   <= w_zero ? '1 : '0;
                r_rem <= w_zero ? {1'b0, dividend} : '0;
            end
        end else if (r_state == ST_BUSY) begin
            r_rem <= w_rem_step;
            r_q   <= {r_q[WIDTH-2:0], w_q_bit};
            r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks for seq_divider at WIDTH=4 and WIDTH=8.
module tb_seq_divider;

    logic       clk;
    logic       rst_n;

    logic       v4, rdy4, ov4, or4, dz4;
    logic [3:0] a4, b4, q4, r4;

    logic       v8, rdy8, ov8, or8, dz8;
    logic [7:0] a8, b8, q8, r8;

    int n_tests;
    int n_fail;

    seq_divider #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v4), .in_ready(rdy4),
        .dividend(a4), .divisor(b4),
        .out_valid(ov4), .out_ready(or4),
        .quotient(q4), .remainder(r4),
        .div_by_zero(dz4)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(rdy8),
        .dividend(a8), .divisor(b8),
        .out_valid(ov8), .out_ready(or8),
        .quotient(q8), .remainder(r8),
        .div_by_zero(dz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Presents one operand pair and waits for out_valid (not consumed).
    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        output int cyc);
        int n;
        n = 0;
        while (!rdy4 && n < 50) begin
            step();
            n++;
        end
        a4 = a;
        b4 = b;
        v4 = 1'b1;
        step();
        v4 = 1'b0;
        cyc = 1;
        while (!ov4 && cyc < 50) begin
            step();
            cyc++;
        end
        chk("w4_valid_timeout", {31'd0, ov4}, 32'd1);
    endtask

    task automatic drain4(input logic [3:0] eq, input logic [3:0] er);
        or4 = 1'b1;
        step();
        or4 = 1'b0;
        chk("w4_valid_drop", {31'd0, ov4}, 32'd0);
        chk("w4_ready_back", {31'd0, rdy4}, 32'd1);
        chk("w4_q_kept", {28'd0, q4}, {28'd0, eq});
        chk("w4_r_kept", {28'd0, r4}, {28'd0, er});
    endtask

    initial begin
        int cyc;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        v4 = 0; or4 = 0; a4 = 0; b4 = 0;
        v8 = 0; or8 = 0; a8 = 0; b8 = 0;

        vecs[0] = '{4'd13, 4'd4,  4'd3,  4'd1, 1'b0, 5};
        vecs[1] = '{4'd9,  4'd0,  4'hF,  4'd9, 1'b1, 1};
        vecs[2] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 5};
        vecs[3] = '{4'd0,  4'd7,  4'd0,  4'd0, 1'b0, 5};
        vecs[4] = '{4'd3,  4'd12, 4'd0,  4'd3, 1'b0, 5};
        vecs[5] = '{4'd14, 4'd3,  4'd4,  4'd2, 1'b0, 5};
        vecs[6] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 5};
        vecs[7] = '{4'd7,  4'd8,  4'd0,  4'd7, 1'b0, 5};
        vecs[8] = '{4'd0,  4'd0,  4'hF,  4'd0, 1'b1, 1};

        step();
        step();
        rst_n = 1'b1;
        chk("rst_valid", {31'd0, ov4}, 32'd0);
        chk("rst_q", {28'd0, q4}, 32'd0);
        chk("rst_r", {28'd0, r4}, 32'd0);
        chk("rst_dz", {31'd0, dz4}, 32'd0);
        chk("rst_ready", {31'd0, rdy4}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            run4(vecs[i].a, vecs[i].b, cyc);
            chk($sformatf("v%0d_q", i), {28'd0, q4}, {28'd0, vecs[i].q});
            chk($sformatf("v%0d_r", i), {28'd0, r4}, {28'd0, vecs[i].r});
            chk($sformatf("v%0d_dz", i), {31'd0, dz4}, {31'd0, vecs[i].dz});
            chk($sformatf("v%0d_lat", i), cyc, vecs[i].lat);
            drain4(vecs[i].q, vecs[i].r);
        end

        // Backpressure: hold result, ignore new operands, no overlap on drain.
        run4(4'd13, 4'd4, cyc);
        for (int k = 0; k < 6; k++) begin
            a4 = 4'd7;
            b4 = 4'd2;
            v4 = 1'b1;
            step();
            chk("bp_valid", {31'd0, ov4}, 32'd1);
            chk("bp_q", {28'd0, q4}, 32'd3);
            chk("bp_r", {28'd0, r4}, 32'd1);
            chk("bp_ready", {31'd0, rdy4}, 32'd0);
        end
        or4 = 1'b1;
        step();
        or4 = 1'b0;
        v4 = 1'b0;
        chk("bp_drain_valid", {31'd0, ov4}, 32'd0);
        step();
        step();
        chk("bp_no_overlap_ready", {31'd0, rdy4}, 32'd1);
        chk("bp_no_overlap_valid", {31'd0, ov4}, 32'd0);

        // Reset in the middle of an iteration.
        a4 = 4'd13;
        b4 = 4'd4;
        v4 = 1'b1;
        step();
        v4 = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_valid", {31'd0, ov4}, 32'd0);
        chk("mid_rst_q", {28'd0, q4}, 32'd0);
        chk("mid_rst_r", {28'd0, r4}, 32'd0);
        chk("mid_rst_ready", {31'd0, rdy4}, 32'd1);
        run4(4'd10, 4'd3, cyc);
        chk("post_rst_q", {28'd0, q4}, 32'd3);
        chk("post_rst_r", {28'd0, r4}, 32'd1);
        chk("post_rst_lat", cyc, 5);
        drain4(4'd3, 4'd1);

        // WIDTH=8 randomized pairs with random consumer stalls.
        for (int i = 0; i < 500; i++) begin
            logic [7:0] a, b, eq, er;
            logic       edz, got, done, d;
            int         n;
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (b == 8'd0) begin
                eq = 8'hFF;
                er = a;
                edz = 1'b1;
            end else begin
                eq = a / b;
                er = a % b;
                edz = 1'b0;
            end
            n = 0;
            while (!rdy8 && n < 50) begin
                step();
                n++;
            end
            a8 = a;
            b8 = b;
            v8 = 1'b1;
            or8 = 1'b0;
            step();
            v8 = 1'b0;
            got = 1'b0;
            done = 1'b0;
            n = 0;
            while (!done && n < 100) begin
                if (ov8 && !got) begin
                    chk("w8_q", {24'd0, q8}, {24'd0, eq});
                    chk("w8_r", {24'd0, r8}, {24'd0, er});
                    chk("w8_dz", {31'd0, dz8}, {31'd0, edz});
                    got = 1'b1;
                end else if (ov8) begin
                    chk("w8_hold_q", {24'd0, q8}, {24'd0, eq});
                end
                or8 = 1'($urandom_range(0, 1));
                d = ov8 && or8;
                step();
                n++;
                if (d) done = 1'b1;
            end
            or8 = 1'b0;
            chk("w8_complete", {31'd0, done}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
